// File: rtl/cnt_sync_updn_if.sv
// Bundle for the presettable up/down counter cell.
// Control, load data, state and ripple carry travel together.
interface cnt_sync_updn_if #(
    parameter int unsigned WIDTH = 4
);
    logic             LOAD_N;
    logic             ENP;
    logic             ENT;
    logic             UP;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             RCO;

    modport master (
        output LOAD_N, ENP, ENT, UP, D,
        input  Q, RCO
    );

    modport slave (
        input  LOAD_N, ENP, ENT, UP, D,
        output Q, RCO
    );
endinterface

// File: rtl/cnt_sync_updn.sv
// Synchronous presettable up/down counter with configurable modulus.
// Cascades through ENP/ENT/RCO like the classic '163/'191 parts.
module cnt_sync_updn #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input logic            CLK,
    input logic            RST_N,
    cnt_sync_updn_if.slave bus
);
    localparam longint unsigned MAX_MOD = 64'd1 << WIDTH;
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 64'd1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("cnt_sync_updn: WIDTH out of range");
    end
    if (MODULUS < 2 || MODULUS > MAX_MOD) begin : g_bad_mod
        $error("cnt_sync_updn: MODULUS out of range");
    end
    if ($bits(bus.D) != WIDTH) begin : g_bad_bus
        $error("cnt_sync_updn: interface WIDTH mismatch");
    end

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_up;
    logic [WIDTH-1:0] q_dn;

    // Out-of-range states fold back into 0..TOP on the next count.
    always_comb begin
        q_up = q + WIDTH'(1);
        q_dn = q - WIDTH'(1);
        if (q >= TOP) begin
            q_up = '0;
        end
        if (q == '0 || q > TOP) begin
            q_dn = TOP;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q <= '0;
        end else if (!bus.LOAD_N) begin
            q <= bus.D;
        end else if (bus.ENP && bus.ENT) begin
            q <= bus.UP ? q_up : q_dn;
        end
    end

    assign bus.Q   = q;
    assign bus.RCO = bus.ENT
                   & (bus.UP ? (q == TOP) : (q == '0));
endmodule

// File: doc/cnt_sync_updn.md
Name: cnt_sync_updn

Overview:
- Parametrised synchronous presettable up/down counter macro-cell for the RV523 discrete-cell library.
- It is the first clocked member of the gate family and generalises the classic 4-bit '163/'191 counter.
- WIDTH and wrap modulus are configurable, so one cell covers binary, BCD and arbitrary-modulus counters.
- Cascadable through ENP/ENT/RCO for the PC, cycle counter and shift-amount sequencing in the RV523 datapath.

Parameters:
WIDTH, 4, counter width in bits; legal range 1..32.
MODULUS, 2**WIDTH, count wraps after MODULUS states (0..MODULUS-1); legal range 2..2**WIDTH; an illegal value is an elaboration error.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
RST_N  input  1  synchronous active-low reset.
LOAD_N  input  1  synchronous active-low parallel load.
ENP  input  1  count enable, parallel; does not gate RCO.
ENT  input  1  count enable, trickle; gates RCO for cascading.
UP  input  1  direction: 1 = count up, 0 = count down.
D  input  WIDTH  parallel load data.
Q  output  WIDTH  counter state (registered).
RCO  output  1  ripple carry out (combinational).

Behaviour:
- Reset and polarity: one clock CLK; RST_N is synchronous and active-low. RST_N=0 at a rising CLK edge forces Q=0. RST_N has no asynchronous effect.
- Priority at each rising edge: reset > load > count > hold.
- Load: if LOAD_N=0, Q <= D on that edge, regardless of ENP/ENT/UP. D values >= MODULUS are loaded unmodified.
- Count: if LOAD_N=1 and ENP=1 and ENT=1, Q advances one step.
  - Up: Q <= 0 if Q >= MODULUS-1, else Q+1.
  - Down: Q <= MODULUS-1 if Q == 0 or Q > MODULUS-1, else Q-1.
  - Out-of-range state therefore returns to the legal range within one count.
- Hold: otherwise Q is unchanged.
- Latency: Q reflects load or count exactly one edge after the qualifying inputs.
- RCO = ENT & (UP ? (Q == MODULUS-1) : (Q == 0)).
  - Purely combinational from ENT, UP and Q; independent of ENP, LOAD_N and RST_N.
  - RCO=0 whenever ENT=0.
- Cascade: stage n+1 has ENT tied to RCO of stage n and shares ENP and CLK. The chain then counts as one WIDTH*k-bit (or product-modulus) counter with no extra latency.
- UP changing on the same edge as a count: the new UP value is the one sampled. RCO follows UP immediately (combinationally).
- Reset during load or count: reset wins. Q=0 on that edge, and RCO is re-evaluated from Q=0.
- After reset with ENT=1 and UP=0, RCO=1 (Q==0 terminal for down-count). With UP=1, RCO=0 unless MODULUS==1, which is illegal.
- WIDTH=1, MODULUS=2: the cell behaves as a toggle flip-flop with enable.
- No X propagation: Q is defined from the first reset edge onward.
- Output before the first reset edge is don't-care. The bench must assert RST_N for at least one edge before checking.

Test Plan:
- Reset: WIDTH=4, load D=9, then RST_N=0 for one edge with LOAD_N=0 and ENP=ENT=1 -> Q=0 after the edge; UP=0, ENT=1 gives RCO=1.
- Binary up wrap: WIDTH=4, default MODULUS, UP=1, ENP=ENT=1, 17 edges from Q=0 -> Q walks 1..15, 0, 1. RCO=1 only while Q=15.
- BCD mode: MODULUS=10, UP=1, counting from 8 -> 9 (RCO=1), then 0. Down from 0 -> 9. Load D=13, then one up count -> Q=0; load D=13, then one down count -> Q=9.
- Enables and priority: ENP=0, ENT=1 with Q=15 and UP=1 -> Q holds and RCO=1. ENT=0 -> Q holds and RCO=0. LOAD_N=0 with D=5, ENP=ENT=1 -> Q=5 (load beats count).
- Cascade: two WIDTH=4 stages, stage1.ENT = stage0.RCO, start at 0x0F, UP=1, one edge -> {Q1,Q0}=0x10. Then count down from 0x10 -> 0x0F in one edge.
- Direction flip mid-run: Q=7 counting up, UP dropped on the next edge -> Q=6. RCO tracks UP in the same cycle: Q=0 with UP toggling 1->0 makes RCO go 0->1 without a clock.
